multiplicador_sequencial: RTL

MULTIPLICADOR_SEQUENCIAL -- requirements
Module: multiplicador_sequencial

---
 rtl/multiplicador_sequencial.sv | 113 +++++++++++
 1 files changed

// File: rtl/multiplicador_sequencial.sv
// Sequential 4x4 unsigned shift-add multiplier driving an external 4-bit adder.
// Latency: start at edge k -> busy after k..k+3, done pulse after k+4, IDLE after k+5.
// Backpressure: none; start is honoured only in IDLE and ignored while CALC/DONE run.
// Optional build macro MULT_ZERO_BYPASS_EN: a zero operand skips CALC and goes straight to DONE.
module multiplicador_sequencial (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] multiplicando,
  input  logic [3:0] multiplicador,
  output logic       busy,
  output logic       done,
  output logic [7:0] produto,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  output logic       add_cin,
  input  logic [4:0] add_s
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] m_reg;
  logic [3:0] q_reg;
  logic [3:0] acc;
  logic [1:0] cnt;
  logic       last_step;
  logic       zero_op;
  logic [8:0] shift_nxt;

  // A zero operand can only short-circuit the datapath when the bypass is built in.
`ifdef MULT_ZERO_BYPASS_EN
  assign zero_op = (multiplicando == 4'd0) || (multiplicador == 4'd0);
`else
  assign zero_op = 1'b0;
`endif

  // The 9-bit {carry, sum, Q} word shifted right by one: new accumulator and multiplier.
  assign shift_nxt = {add_s, q_reg[3:1]};
  assign last_step = (cnt == 2'd3);

  // Next-state decode; the unused encoding falls back to IDLE.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = zero_op ? DONE : CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: state_nxt = last_step ? DONE : CALC;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand, accumulator, step counter and product registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      m_reg   <= 4'd0;
      q_reg   <= 4'd0;
      acc     <= 4'd0;
      cnt     <= 2'd0;
      produto <= 8'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= multiplicando;
            q_reg <= multiplicador;
            acc   <= 4'd0;
            cnt   <= 2'd0;
            if (zero_op) begin
              produto <= 8'd0;
            end
          end
        end
        CALC: begin
          {acc, q_reg} <= shift_nxt;
          cnt          <= cnt + 2'd1;
          // The product is the shifted word formed on the final step, captured as DONE is entered.
          if (last_step) begin
            produto <= shift_nxt[7:0];
          end
        end
        default: begin
          // DONE holds everything; produto stays until the next DONE entry.
        end
      endcase
    end
  end

  // Status flags and adder operands; the adder sees zeros whenever no step is running.
  always_comb begin
    busy    = (state == CALC);
    done    = (state == DONE);
    add_cin = 1'b0;
    add_a   = 4'd0;
    add_b   = 4'd0;
    if (state == CALC) begin
      add_a = acc;
      add_b = q_reg[0] ? m_reg : 4'd0;
    end
  end

endmodule
